mod_exp: RTL and testbench

Modular exponentiation engine computing result = a^b mod m by right-to-left square-and-multiply. It sits directly upstream of the shift-add modular multiplier and drives it. It issues one multiply per set exponent bit and one squaring per remaining exponent bit, then returns the reduced power. Its start/done handshake matches the multiplier's, so it can be chained into a larger arithmetic controller.

---
 rtl/mod_exp_pkg.sv | 12 +
 rtl/mod_exp_if.sv | 16 +
 rtl/mod_exp_mul.sv | 76 +++++++
 rtl/mod_exp.sv | 94 +++++++++
 tb/tb_mod_exp.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/mod_exp_pkg.sv
// Shared width default and FSM encodings for the modular exponentiation engine
// and its shift-add multiplier.
package mod_exp_pkg;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [3:0] {
        IDLE, INIT, CHECK, MUL_GO, MUL_SKIP, MUL_WAIT,
        SHIFT, SQ_GO, SQ_SKIP, SQ_WAIT, FINISH
    } state_t;

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_FIN} mul_state_t;
endpackage

// File: rtl/mod_exp_if.sv
// start/done request bus of the exponentiation engine.
interface mod_exp_if
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] result;
    logic             done;

    modport master (output start, a, b, m, input result, done);
    modport slave  (input start, a, b, m, output result, done);
endinterface

// File: rtl/mod_exp_mul.sv
// Shift-add modular multiplier: result = a*b mod m, one multiplier bit per cycle.
// Operands must be below m and m below 2^(WIDTH-1) so sums never overflow.
module mod_mul
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             done
);
    mul_state_t state, next_state;
    logic [WIDTH-1:0] x, y, acc;
    logic [WIDTH:0]   sum, sum_sub, dbl, dbl_sub;
    logic [WIDTH-1:0] sum_red, dbl_red;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, x};
        sum_sub = sum - {1'b0, m};
        sum_red = (sum >= {1'b0, m}) ? sum_sub[WIDTH-1:0] : sum[WIDTH-1:0];
        dbl     = {x, 1'b0};
        dbl_sub = dbl - {1'b0, m};
        dbl_red = (dbl >= {1'b0, m}) ? dbl_sub[WIDTH-1:0] : dbl[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= M_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            M_IDLE:  if (start) next_state = M_RUN;
            M_RUN:   if (y == '0) next_state = M_FIN;
            M_FIN:   next_state = M_IDLE;
            default: next_state = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x      <= '0;
            y      <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                M_IDLE: begin
                    done <= ~start;
                    if (start) begin
                        x   <= a;
                        y   <= b;
                        acc <= '0;
                    end
                end
                M_RUN: if (y != '0) begin
                    if (y[0]) acc <= sum_red;
                    x <= dbl_red;
                    y <= y >> 1;
                end
                M_FIN: begin
                    result <= acc;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mod_exp.sv
// Right-to-left square-and-multiply a^b mod m driving one shared mod_mul.
module mod_exp
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic    clk,
    input  logic    reset,
    mod_exp_if.slave bus
);
    state_t state, next_state;
    logic [WIDTH-1:0] base, expo, modulus, acc;
    logic [WIDTH-1:0] mul_a, mul_b, mul_res;
    logic             mul_start, mul_done;

    mod_mul #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (mul_a),
        .b      (mul_b),
        .m      (modulus),
        .result (mul_res),
        .done   (mul_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (bus.start) next_state = INIT;
            INIT:     next_state = CHECK;
            CHECK:    next_state = (expo == '0) ? FINISH : (expo[0] ? MUL_GO : SHIFT);
            MUL_GO:   next_state = MUL_SKIP;
            MUL_SKIP: next_state = MUL_WAIT;
            MUL_WAIT: if (mul_done) next_state = SHIFT;
            SHIFT:    next_state = ((expo >> 1) == '0) ? FINISH : SQ_GO;
            SQ_GO:    next_state = SQ_SKIP;
            SQ_SKIP:  next_state = SQ_WAIT;
            SQ_WAIT:  if (mul_done) next_state = CHECK;
            FINISH:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Operands load one state ahead of GO so they are stable for the whole call.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base       <= '0;
            expo       <= '0;
            modulus    <= '0;
            acc        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_start  <= 1'b0;
            bus.result <= '0;
            bus.done   <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    bus.done <= ~bus.start;
                    if (bus.start) begin
                        base    <= bus.a;
                        expo    <= bus.b;
                        modulus <= bus.m;
                    end
                end
                INIT: acc <= (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                CHECK: if (expo != '0 && expo[0]) begin
                    mul_a <= acc;
                    mul_b <= base;
                end
                MUL_GO, SQ_GO: mul_start <= 1'b1;
                MUL_WAIT: if (mul_done) acc <= mul_res;
                SHIFT: begin
                    expo  <= expo >> 1;
                    mul_a <= base;
                    mul_b <= base;
                end
                SQ_WAIT: if (mul_done) base <= mul_res;
                FINISH: begin
                    bus.result <= acc;
                    bus.done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_exp.sv
// Directed vectors plus reset-abort and back-to-back sequences for mod_exp.
module tb_mod_exp;
    import mod_exp_pkg::*;

    localparam int LIMIT = 20000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m;
        logic [31:0] res;
        int          cyc;   // 0 = latency not checked
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mod_exp_if #(.WIDTH(32)) bus();

    mod_exp #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_exp(input logic [31:0] a, b, m);
        longint unsigned r, x, mm;
        mm = {32'b0, m};
        r  = (m == 32'd1) ? 64'd0 : 64'd1;
        x  = {32'b0, a};
        for (int i = 0; i < 32; i++) begin
            if (b[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[31:0];
    endfunction

    task automatic run(input logic [31:0] a, b, m, output logic [31:0] res, output int cyc);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.m = m; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = '1; bus.b = '1; bus.m = '1;
        cyc = 1;
        check("done_fall", {31'b0, bus.done}, 32'd0);
        while (!bus.done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) check("timeout", {31'b0, bus.done}, 32'd1);
        res = bus.result;
    endtask

    vec_t        vecs [9];
    logic [31:0] res;
    int          cyc;

    initial begin
        vecs[0] = '{32'd3,       32'd5,          32'd7,          32'd5,  0};
        vecs[1] = '{32'd2,       32'd10,         32'd1000,       32'd24, 0};
        vecs[2] = '{32'd5,       32'd0,          32'd7,          32'd1,  4};
        vecs[3] = '{32'd0,       32'd3,          32'd1,          32'd0,  0};
        vecs[4] = '{32'd0,       32'd0,          32'd13,         32'd1,  4};
        vecs[5] = '{32'd5,       32'd0,          32'd1,          32'd0,  4};
        vecs[6] = '{32'd6,       32'd2,          32'd11,         32'd3,  0};
        vecs[7] = '{32'd7,       32'd13,         32'd100,        32'd7,  0};
        vecs[8] = '{32'h12345,   32'hFFFFFFFF,   32'h7FFFFFFF,   32'd0,  0};
        vecs[8].res = ref_exp(vecs[8].a, vecs[8].b, vecs[8].m);

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.m = '0;
        repeat (2) @(negedge clk);
        check("rst_result", bus.result, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_release_done", {31'b0, bus.done}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            run(vecs[i].a, vecs[i].b, vecs[i].m, res, cyc);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            if (vecs[i].cyc != 0) check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
        end

        // Abort a long run while it waits on the multiplier.
        @(negedge clk);
        bus.a = 32'h12345; bus.b = 32'hFFFFFFFF; bus.m = 32'h7FFFFFFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (100) @(negedge clk);
        cyc = 0;
        while (dut.state != MUL_WAIT && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_mul_wait", {28'b0, dut.state}, {28'b0, MUL_WAIT});
        reset = 1'b0;
        #1;
        check("abort_result", bus.result, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_release_done", {31'b0, bus.done}, 32'd1);
        run(32'd3, 32'd5, 32'd7, res, cyc);
        check("after_abort_result", res, 32'd5);

        // Back-to-back with start held high across completion.
        @(negedge clk);
        bus.a = 32'd2; bus.b = 32'd3; bus.m = 32'd5; bus.start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < LIMIT);
        check("b2b_first_done", {31'b0, bus.done}, 32'd1);
        check("b2b_first_result", bus.result, 32'd3);
        bus.a = 32'd4; bus.b = 32'd2; bus.m = 32'd9;
        @(negedge clk);
        check("b2b_done_pulse", {31'b0, bus.done}, 32'd0);
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.a = 32'd1; bus.b = 32'd1; bus.m = 32'd3; bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            @(negedge clk);
        end
        check("busy_ignores_start", {31'b0, bus.done}, 32'd0);
        cyc = 0;
        while (!bus.done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_second_done", {31'b0, bus.done}, 32'd1);
        check("b2b_second_result", bus.result, 32'd7);
        repeat (3) @(negedge clk);
        check("result_held", bus.result, 32'd7);
        check("done_held", {31'b0, bus.done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
